// File: rtl/adder_output_collector.sv
// adder_output_collector
// Row-serial back end of the adder/multiplier datapath. It takes one adder row
// (sum word plus carry-out) per handshake and returns the next row's A operand.
// It shifts each row LSB out as a product bit, assembles the 2*W-bit result and
// presents that result over a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 begin an operation (accepted in IDLE or DONE)
//   sum_funct             sampled at start: 1 = add (one row), 0 = multiply (W-1 rows)
//   carryless             sampled at start: 1 = row carries forced to 0
//   p0                    sampled at start: product bit 0 (multiply only)
//   row_valid/row_ready   row handshake; row_sum, row_carry form the row payload
//   row_index             index of the next row expected
//   next_a                feedback operand {carry, row_sum[W-1:1]} of the last row
//   busy                  high while collecting rows
//   result_lo/result_hi   result bits [W-1:0] / [2W-1:W]
//   result_valid/result_ready  result handshake
module adder_output_collector #(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned IDX_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sum_funct,
  input  logic                  carryless,
  input  logic                  p0,
  input  logic                  row_valid,
  input  logic [DATA_WIDTH-1:0] row_sum,
  input  logic                  row_carry,
  output logic                  row_ready,
  output logic [IDX_W-1:0]      row_index,
  output logic [DATA_WIDTH-1:0] next_a,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] result_lo,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam int unsigned W        = DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(W - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   mode_sum;
  logic   mode_cl;
  logic   start_acc;
  logic   row_xfer;
  logic   last_row;
  logic   carry_m;
  logic [W-1:0] lo_sel;

  // Carry seen by the result and the feedback path; dropped in GF(2) mode.
  assign carry_m = row_carry & ~mode_cl;

  // One-hot position of the product bit produced by the current multiply row.
  assign lo_sel = W'(1) << ({1'b0, row_index} + (IDX_W + 1)'(1));

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    row_xfer  = 1'b0;
    last_row  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          start_acc = 1'b1;
        end
      end
      COLLECT: begin
        row_xfer = row_valid;
        last_row = row_valid & (mode_sum | (row_index == LAST_ROW));
        if (last_row) state_d = DONE;
      end
      DONE: begin
        // A new start wins over consuming the old result.
        if (start) begin
          state_d   = COLLECT;
          start_acc = 1'b1;
        end else if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, registered status flags and the datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_ready    <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      mode_sum     <= 1'b0;
      mode_cl      <= 1'b0;
      row_index    <= '0;
      next_a       <= '0;
      result_lo    <= '0;
      result_hi    <= '0;
    end else begin
      state_q      <= state_d;
      row_ready    <= (state_d == COLLECT);
      busy         <= (state_d == COLLECT);
      result_valid <= (state_d == DONE);
      if (start_acc) begin
        mode_sum  <= sum_funct;
        mode_cl   <= carryless;
        row_index <= '0;
        next_a    <= '0;
        result_hi <= '0;
        result_lo <= sum_funct ? '0 : W'(p0);
      end else if (row_xfer) begin
        next_a    <= {carry_m, row_sum[W-1:1]};
        row_index <= row_index + IDX_W'(1);
        if (mode_sum) begin
          result_lo <= row_sum;
          result_hi <= W'(carry_m);
        end else begin
          result_lo <= (result_lo & ~lo_sel) | ({W{row_sum[0]}} & lo_sel);
          if (last_row) result_hi <= {carry_m, row_sum[W-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_output_collector.sv
// Self-checking bench for adder_output_collector at W=4. The bench plays the
// adder: random operands are multiplied row by row and the collected result is
// compared with the arithmetic (or GF(2)) product of the operands.
module tb_adder_output_collector;

  localparam int unsigned W  = 4;
  localparam int unsigned IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sum_funct = 1'b0;
  logic          carryless = 1'b0;
  logic          p0 = 1'b0;
  logic          row_valid = 1'b0;
  logic [W-1:0]  row_sum = '0;
  logic          row_carry = 1'b0;
  logic          result_ready = 1'b0;
  logic          row_ready;
  logic [IW-1:0] row_index;
  logic [W-1:0]  next_a;
  logic          busy;
  logic [W-1:0]  result_lo;
  logic [W-1:0]  result_hi;
  logic          result_valid;

  int vectors = 0;
  int miscompares = 0;

  adder_output_collector #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sum_funct(sum_funct),
    .carryless(carryless), .p0(p0), .row_valid(row_valid), .row_sum(row_sum),
    .row_carry(row_carry), .row_ready(row_ready), .row_index(row_index),
    .next_a(next_a), .busy(busy), .result_lo(result_lo), .result_hi(result_hi),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // Reference product: integer multiply or carry-less (XOR) multiply.
  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                                  input bit cl);
    logic [2*W-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(W); i++)
      if (b[i]) acc = cl ? (acc ^ ((2*W)'(a) << i)) : (acc + ((2*W)'(a) << i));
    return acc;
  endfunction

  task automatic do_start(input bit sf, input bit cl, input bit pb);
    start = 1'b1; sum_funct = sf; carryless = cl; p0 = pb;
    @(posedge clk); #1;
    start = 1'b0; sum_funct = 1'($urandom); carryless = 1'($urandom); p0 = 1'($urandom);
  endtask

  task automatic send_row(input logic [W-1:0] s, input bit c);
    row_valid = 1'b1; row_sum = s; row_carry = c;
    @(posedge clk); #1;
    row_valid = 1'b0; row_sum = W'($urandom); row_carry = 1'($urandom);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic consume();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({row_ready, busy, result_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 000", {row_ready, busy, result_valid});
    end
    vectors++;
    if ({row_index, next_a, result_hi, result_lo} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got idx=%0d na=%h r=%h%h want all zero",
               row_index, next_a, result_hi, result_lo);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    gap(1);
  endtask

  task automatic test_directed_mul();
    do_start(1'b0, 1'b0, 1'b1);
    vectors++;
    if ({busy, row_ready, result_valid} !== 3'b110) begin
      miscompares++;
      $display("FAIL start_flags got %b want 110", {busy, row_ready, result_valid});
    end
    send_row(4'b0011, 1'b0);
    vectors++;
    if (next_a !== 4'b0001) begin
      miscompares++;
      $display("FAIL next_a_row0 got %b want 0001", next_a);
    end
    send_row(4'b0001, 1'b0);
    vectors++;
    if (result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_valid got %b want 0", result_valid);
    end
    send_row(4'b0001, 1'b0);
    vectors++;
    if ({result_valid, row_index, result_hi, result_lo} !== {1'b1, 2'd3, 8'h0F}) begin
      miscompares++;
      $display("FAIL mul_0f got v=%b idx=%0d r=%h%h want v=1 idx=3 r=0f",
               result_valid, row_index, result_hi, result_lo);
    end
    consume();
    vectors++;
    if ({result_valid, busy, result_hi, result_lo} !== {2'b00, 8'h0F}) begin
      miscompares++;
      $display("FAIL idle_hold got v=%b b=%b r=%h%h want v=0 b=0 r=0f",
               result_valid, busy, result_hi, result_lo);
    end
    // Last row 1111 with carry: its LSB lands in bit W-1, upper bits in result_hi.
    for (int m = 0; m < 2; m++) begin
      do_start(1'b0, 1'(m), 1'b0);
      send_row(4'b0110, 1'b0);
      send_row(4'b1010, 1'b1);
      send_row(4'b1111, 1'b1);
      vectors++;
      if ({result_hi, result_lo} !== ((m == 0) ? 8'hF8 : 8'h78)) begin
        miscompares++;
        $display("FAIL mul_last_row cl=%0d got %h%h want %h", m, result_hi, result_lo,
                 (m == 0) ? 8'hF8 : 8'h78);
      end
      vectors++;
      if (next_a !== ((m == 0) ? 4'hF : 4'h7)) begin
        miscompares++;
        $display("FAIL next_a_last cl=%0d got %h want %h", m, next_a,
                 (m == 0) ? 4'hF : 4'h7);
      end
      consume();
    end
  endtask

  task automatic test_sum();
    do_start(1'b1, 1'b0, 1'b1);
    send_row(4'b1010, 1'b1);
    vectors++;
    if ({result_valid, row_index, result_hi, result_lo} !== {1'b1, 2'd1, 4'h1, 4'hA}) begin
      miscompares++;
      $display("FAIL sum_basic got v=%b idx=%0d r=%h%h want v=1 idx=1 r=1a",
               result_valid, row_index, result_hi, result_lo);
    end
    // A row offered in DONE must not be taken.
    send_row(4'b0101, 1'b0);
    vectors++;
    if ({row_ready, next_a, result_hi, result_lo} !== {1'b0, 4'hD, 8'h1A}) begin
      miscompares++;
      $display("FAIL done_row_ignored got rdy=%b na=%h r=%h%h want rdy=0 na=d r=1a",
               row_ready, next_a, result_hi, result_lo);
    end
    do_start(1'b1, 1'b1, 1'b1);
    send_row(4'b1111, 1'b1);
    vectors++;
    if ({result_hi, result_lo} !== 8'h0F) begin
      miscompares++;
      $display("FAIL sum_carryless got %h%h want 0f", result_hi, result_lo);
    end
    consume();
  endtask

  task automatic test_stall();
    do_start(1'b0, 1'b0, 1'b1);
    send_row(4'b0011, 1'b0);
    gap(2);
    vectors++;
    if ({row_index, busy} !== {2'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL stall_hold got idx=%0d busy=%b want idx=1 busy=1", row_index, busy);
    end
    send_row(4'b0001, 1'b0);
    send_row(4'b0001, 1'b0);
    vectors++;
    if ({result_hi, result_lo} !== 8'h0F) begin
      miscompares++;
      $display("FAIL stall_result got %h%h want 0f", result_hi, result_lo);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (result_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL valid_held cycle %0d got %b want 1", i, result_valid);
      end
      gap(1);
    end
    consume();
    vectors++;
    if (result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL valid_drop got %b want 0", result_valid);
    end
  endtask

  task automatic test_start_restart();
    do_start(1'b0, 1'b0, 1'b0);
    send_row(4'b0001, 1'b0);
    start = 1'b1; sum_funct = 1'b1; p0 = 1'b1;
    send_row(4'b0010, 1'b0);
    start = 1'b0;
    vectors++;
    if ({row_index, busy, result_valid} !== {2'd2, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL start_in_collect got idx=%0d busy=%b v=%b want idx=2 busy=1 v=0",
               row_index, busy, result_valid);
    end
    send_row(4'b0101, 1'b0);
    vectors++;
    if ({result_hi, result_lo} !== 8'h2A) begin
      miscompares++;
      $display("FAIL start_ignored_result got %h%h want 2a", result_hi, result_lo);
    end
    result_ready = 1'b1;
    do_start(1'b0, 1'b0, 1'b1);
    result_ready = 1'b0;
    vectors++;
    if ({busy, result_valid, row_index, next_a, result_hi, result_lo} !==
        {1'b1, 1'b0, 2'd0, 4'h0, 8'h01}) begin
      miscompares++;
      $display("FAIL restart_in_done got b=%b v=%b idx=%0d na=%h r=%h%h want b=1 v=0 idx=0 na=0 r=01",
               busy, result_valid, row_index, next_a, result_hi, result_lo);
    end
    send_row(4'b0000, 1'b0);
    send_row(4'b0000, 1'b0);
    send_row(4'b0000, 1'b0);
    vectors++;
    if ({result_valid, result_hi, result_lo} !== {1'b1, 8'h01}) begin
      miscompares++;
      $display("FAIL restart_result got v=%b r=%h%h want v=1 r=01",
               result_valid, result_hi, result_lo);
    end
    consume();
  endtask

  // Acts as the adder for one operation and checks feedback, latency and result.
  task automatic run_random_op(input bit allow_gaps);
    logic [W-1:0] a, b, fa, pp, s, exp_na;
    logic [2*W-1:0] exp_res;
    logic [W:0] wide;
    bit cl, c, is_sum;
    a = W'($urandom); b = W'($urandom);
    cl = 1'($urandom); is_sum = ($urandom_range(0, 3) == 0);
    if (is_sum) begin
      s = W'($urandom); c = 1'($urandom);
      do_start(1'b1, cl, 1'($urandom));
      if (allow_gaps) gap($urandom_range(0, 2));
      send_row(s, c);
      exp_res = {(W-1)'(0), c & ~cl, s};
    end else begin
      do_start(1'b0, cl, a[0] & b[0]);
      pp = b[0] ? a : '0;
      fa = {1'b0, pp[W-1:1]};
      for (int k = 0; k <= int'(W) - 2; k++) begin
        pp = b[k+1] ? a : '0;
        if (cl) begin
          s = fa ^ pp; c = 1'($urandom);
        end else begin
          wide = (W+1)'(fa) + (W+1)'(pp);
          s = wide[W-1:0]; c = wide[W];
        end
        if (allow_gaps && ($urandom_range(0, 2) == 0)) gap($urandom_range(1, 2));
        vectors++;
        if (result_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_early_valid row %0d got %b want 0", k, result_valid);
        end
        send_row(s, c);
        exp_na = {c & ~cl, s[W-1:1]};
        vectors++;
        if (next_a !== exp_na) begin
          miscompares++;
          $display("FAIL rand_next_a row %0d got %h want %h", k, next_a, exp_na);
        end
        fa = exp_na;
      end
      exp_res = ref_product(a, b, cl);
    end
    vectors++;
    if ({result_valid, result_hi, result_lo} !== {1'b1, exp_res}) begin
      miscompares++;
      $display("FAIL rand_result sum=%0d cl=%0d a=%h b=%h got v=%b r=%h%h want v=1 r=%h",
               is_sum, cl, a, b, result_valid, result_hi, result_lo, exp_res);
    end
    if ($urandom_range(0, 2) != 0) begin
      gap($urandom_range(0, 2));
      consume();
    end
  endtask

  task automatic test_reset_midop();
    do_start(1'b0, 1'b0, 1'b1);
    send_row(4'b0011, 1'b0);
    send_row(4'b0101, 1'b1);
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({row_ready, busy, result_valid, row_index, next_a, result_hi, result_lo} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got rdy=%b b=%b v=%b idx=%0d na=%h r=%h%h want all zero",
               row_ready, busy, result_valid, row_index, next_a, result_hi, result_lo);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    gap(1);
    run_random_op(1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) run_random_op(1'b1);
  endtask

  initial begin
    test_reset();
    test_directed_mul();
    test_sum();
    test_stall();
    test_start_restart();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
